// File: rtl/target_tracker.sv
// target_tracker: per-frame target-colour statistics (count, centroid, bounding box) for a VGA pixel stream.
// Accumulates during ACCUM, snapshots at the last pixel, then divides serially before publishing.
module target_tracker #(
    parameter int MIN_PIXELS = 64,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DE,
    input  logic [9:0]  x_pixel,
    input  logic [9:0]  y_pixel,
    input  logic        is_target_color,
    output logic        obj_valid,
    output logic [9:0]  centroid_x,
    output logic [9:0]  centroid_y,
    output logic [9:0]  box_x_min,
    output logic [9:0]  box_x_max,
    output logic [9:0]  box_y_min,
    output logic [9:0]  box_y_max,
    output logic [18:0] pixel_count,
    output logic        frame_done
);
    localparam logic [9:0]  H_A   = 10'(H_ACTIVE);
    localparam logic [9:0]  V_A   = 10'(V_ACTIVE);
    localparam logic [9:0]  H_L   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_L   = 10'(V_ACTIVE - 1);
    localparam logic [18:0] MIN_P = 19'(MIN_PIXELS);

    typedef enum logic [2:0] {ACCUM, SNAP, DIV_X, DIV_Y, PUBLISH} state_e;
    state_e state_q, state_d;

    logic        start, last, hit;
    logic [18:0] cnt_q, cnt_d, cnt_b;
    logic [27:0] sx_q, sx_d, sx_b, sy_q, sy_d, sy_b;
    logic [9:0]  xmin_q, xmin_d, xmin_b, xmax_q, xmax_d, xmax_b;
    logic [9:0]  ymin_q, ymin_d, ymin_b, ymax_q, ymax_d, ymax_b;
    logic [18:0] sh_cnt_q;
    logic [27:0] sh_sy_q;
    logic [9:0]  sh_xmin_q, sh_xmax_q, sh_ymin_q, sh_ymax_q;
    logic [27:0] rem_q, quo_q, rem_n, quo_n;
    logic [28:0] trial;
    logic        ge, div_end;
    logic [4:0]  bit_q;
    logic [9:0]  qx_q, qy_q;
    logic        obj_valid_q, frame_done_q;
    logic [9:0]  cx_q, cy_q, bx0_q, bx1_q, by0_q, by1_q;
    logic [18:0] pc_q;

    always_comb begin
        start  = state_q == ACCUM && DE && x_pixel == '0 && y_pixel == '0;
        last   = state_q == ACCUM && DE && x_pixel == H_L && y_pixel == V_L;
        hit    = state_q == ACCUM && DE && is_target_color && x_pixel < H_A && y_pixel < V_A;
        cnt_b  = start ? '0 : cnt_q;
        sx_b   = start ? '0 : sx_q;
        sy_b   = start ? '0 : sy_q;
        xmin_b = start ? 10'h3ff : xmin_q;
        ymin_b = start ? 10'h3ff : ymin_q;
        xmax_b = start ? '0 : xmax_q;
        ymax_b = start ? '0 : ymax_q;
        cnt_d  = hit ? cnt_b + 19'd1 : cnt_b;
        sx_d   = hit ? sx_b + 28'(x_pixel) : sx_b;
        sy_d   = hit ? sy_b + 28'(y_pixel) : sy_b;
        xmin_d = hit && x_pixel < xmin_b ? x_pixel : xmin_b;
        xmax_d = hit && x_pixel > xmax_b ? x_pixel : xmax_b;
        ymin_d = hit && y_pixel < ymin_b ? y_pixel : ymin_b;
        ymax_d = hit && y_pixel > ymax_b ? y_pixel : ymax_b;
    end

    // Restoring divider step: remainder stays below the 19-bit divisor, so 28 bits hold it.
    always_comb begin
        trial   = {rem_q, quo_q[27]};
        ge      = trial >= {10'd0, sh_cnt_q};
        rem_n   = ge ? 28'(trial - {10'd0, sh_cnt_q}) : trial[27:0];
        quo_n   = {quo_q[26:0], ge};
        div_end = bit_q == 5'd27;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   state_d = last ? SNAP : ACCUM;
            SNAP:    state_d = DIV_X;
            DIV_X:   state_d = div_end ? DIV_Y : DIV_X;
            DIV_Y:   state_d = div_end ? PUBLISH : DIV_Y;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ACCUM;
        else state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            sx_q   <= '0;
            sy_q   <= '0;
            xmin_q <= 10'h3ff;
            ymin_q <= 10'h3ff;
            xmax_q <= '0;
            ymax_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            xmin_q <= xmin_d;
            ymin_q <= ymin_d;
            xmax_q <= xmax_d;
            ymax_q <= ymax_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_cnt_q     <= '0;
            sh_sy_q      <= '0;
            sh_xmin_q    <= '0;
            sh_xmax_q    <= '0;
            sh_ymin_q    <= '0;
            sh_ymax_q    <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            bit_q        <= '0;
            qx_q         <= '0;
            qy_q         <= '0;
            obj_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pc_q         <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            bx0_q        <= '0;
            bx1_q        <= '0;
            by0_q        <= '0;
            by1_q        <= '0;
        end else begin
            frame_done_q <= state_q == PUBLISH;
            case (state_q)
                SNAP: begin
                    sh_cnt_q  <= cnt_q;
                    sh_sy_q   <= sy_q;
                    sh_xmin_q <= xmin_q;
                    sh_xmax_q <= xmax_q;
                    sh_ymin_q <= ymin_q;
                    sh_ymax_q <= ymax_q;
                    rem_q     <= '0;
                    quo_q     <= sx_q;
                    bit_q     <= '0;
                end
                DIV_X, DIV_Y: begin
                    rem_q <= div_end ? '0 : rem_n;
                    quo_q <= div_end && state_q == DIV_X ? sh_sy_q : quo_n;
                    bit_q <= div_end ? '0 : bit_q + 5'd1;
                    if (div_end && state_q == DIV_X) qx_q <= quo_n[9:0];
                    if (div_end && state_q == DIV_Y) qy_q <= quo_n[9:0];
                end
                PUBLISH: begin
                    pc_q        <= sh_cnt_q;
                    obj_valid_q <= sh_cnt_q >= MIN_P;
                    if (sh_cnt_q >= MIN_P) begin
                        cx_q  <= qx_q;
                        cy_q  <= qy_q;
                        bx0_q <= sh_xmin_q;
                        bx1_q <= sh_xmax_q;
                        by0_q <= sh_ymin_q;
                        by1_q <= sh_ymax_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign obj_valid   = obj_valid_q;
    assign frame_done  = frame_done_q;
    assign pixel_count = pc_q;
    assign centroid_x  = cx_q;
    assign centroid_y  = cy_q;
    assign box_x_min   = bx0_q;
    assign box_x_max   = bx1_q;
    assign box_y_min   = by0_q;
    assign box_y_max   = by1_q;
endmodule
